ppu_obj_scanner: RTL
====================

// Module: ppu_obj_scanner
// PURPOSE
//  Per-scanline OAM search for the PPU. Scans NUM_OBJ OAM entries at 2 cycles/object and keeps up to MAX_PER_LINE hits.
//  Hits are stored in a double-buffered list, optionally sorted by X. The pixel/sprite fetcher reads the previous
//  line's list through a slot read port while the next line is scanned. Generalises the fixed 2-sprite
//  combinational pick to N objects / M slots with overflow reporting.
// PARAMETERS
//  NUM_OBJ       40  OAM entries scanned (1..64; OAM byte address = 4*i + k)
//  MAX_PER_LINE  10  list slots per line (1..15)
//  SORT_BY_X     1   1: list ordered by X ascending, ties in OAM order; 0: pure OAM order
//  IDX_W         6   object index width
//  SLOT_W        4   slot index width
//  CNT_W         4   hit-count width, >= clog2(MAX_PER_LINE+1)
// PORTS
//  clk        in   1       clock
//  resetn     in   1       synchronous, active-low reset
//  start      in   1       one-cycle pulse: begin scan for 'line'
//  line       in   8       scanline number; sampled on the start edge
//  obj_en     in   1       LCDC[1]; sampled on the start edge
//  tall       in   1       LCDC[2] (8x16); sampled on the start edge
//  oam_rd     out  1       OAM read strobe
//  oam_addr   out  8       OAM byte address
//  oam_rdata  in   8       OAM data; valid 1 cycle after address
//  busy       out  1       scan in progress
//  done       out  1       one-cycle pulse: scan finished, banks swapped
//  overflow   out  1       front bank: more hits than MAX_PER_LINE
//  count      out  CNT_W   front bank: number of valid slots
//  rd_slot    in   SLOT_W  front-bank slot to read
//  rd_valid   out  1       rd_slot < count (combinational)
//  rd_idx     out  IDX_W   OAM index of the slot
//  rd_x       out  8       raw OAM X byte of the slot
//  rd_row     out  4       unflipped row in object: (line+16-Y)[3:0]
// BEHAVIOUR
//  Reset: busy=0, done=0, oam_rd=0, oam_addr=0, front/back bank select=0, both banks count=0 and overflow=0.
//   Slot contents are don't-care because rd_valid=0.
//  FSM: IDLE -> SCAN on start (start ignored while busy) -> FIN -> IDLE.
//   On the start edge E0, latch line/obj_en/tall; clear the back-bank count and overflow; set ptr=0, phase=0.
//  SCAN, cycles 1..2*NUM_OBJ after E0:
//   oam_rd=1; oam_addr = 4*ptr + phase; phase toggles each cycle; ptr increments after phase 1.
//   Cycle sequence: 0,1,4,5,8,9,...
//  Y byte (arrives while the X address is driven):
//   row8 = line + 16 - Y (mod 256); yhit = obj_en && (row8 < (tall ? 16 : 8)).
//   Wrap cases miss, e.g. Y=0/line=0 gives row8=16; Y=255/line=0 gives row8=17.
//  X byte (next cycle): if yhit, insert {ptr, X, row8[3:0]}.
//   X is not range-checked; X=0 or X>=168 objects still occupy a slot.
//  Insert rule:
//   count<MAX: SORT_BY_X=0 appends at slot count.
//    SORT_BY_X=1 places the entry after all entries with x <= X; higher entries shift up one slot.
//    Insert completes in one cycle; count++.
//   count==MAX: entry dropped, overflow=1.
//  Last X byte is consumed at edge E0+2*NUM_OBJ+1 (state FIN).
//   At edge E0+2*NUM_OBJ+2: swap banks, done=1 for that cycle, busy=0; oam_rd=0 from E0+2*NUM_OBJ+1.
//  busy=1 from edge E0+1 through edge E0+2*NUM_OBJ+2 (exclusive).
//  Front bank (count, overflow, rd_*) is stable during SCAN and changes only at the done edge.
//  start coincident with done is accepted (back-to-back lines).
//  resetn low mid-scan: immediate return to reset state; no done pulse.
//  rd_slot >= count or >= MAX: rd_valid=0; rd_idx/rd_x/rd_row=0.
//  Sprite flip, tile and attribute fetch belong to the fetcher, which uses rd_idx.
// TESTING
//  1 NUM_OBJ=40: obj0 Y=16 X=8, others Y=0; start line=0 tall=0
//    -> done exactly 82 cycles after start edge; count=1; slot0 idx=0 x=8 row=0 rd_valid=1; slot1 rd_valid=0.
//  2 objs0..11 Y=20; start line=10
//    -> count=10, overflow=1, slots hold idx 0..9, row=6.
//  3 obj3 X=50, obj5 X=20, obj7 X=50, all Y=16, line=0
//    -> SORT_BY_X=1 order idx 5,3,7; SORT_BY_X=0 order 3,5,7.
//  4 obj0 Y=16, line=15: tall=1 -> hit row=15; tall=0 -> count=0. obj_en=0 -> count=0, done still at 82.
//  5 front list from line 0 read continuously during line 1 scan
//    -> unchanged until done edge. Start pulse at cycle 20 of scan ignored.
//    start on done cycle -> second scan runs.
//  6 resetn low at cycle 30 of scan
//    -> next cycle busy=0, oam_rd=0, count=0, overflow=0; no done; new start scans normally.

Source files
------------

// File: rtl/ppu_obj_scanner.sv
//-----------------------------------------------------------------------------
// ppu_obj_scanner
// Per-scanline OAM search. Walks NUM_OBJ OAM entries (Y then X byte, two
// cycles per object), keeps up to MAX_PER_LINE hits in a double-buffered slot
// list (optionally sorted by X) and exposes the previous line's list to the
// sprite fetcher through a combinational slot read port.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module ppu_obj_scanner #(
  parameter int NUM_OBJ      = 40,
  parameter int MAX_PER_LINE = 10,
  parameter int SORT_BY_X    = 1,
  parameter int IDX_W        = 6,
  parameter int SLOT_W       = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [7:0]        line_i,
  input  logic              obj_en_i,
  input  logic              tall_i,
  output logic              oam_rd_o,
  output logic [7:0]        oam_addr_o,
  input  logic [7:0]        oam_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  count_o,
  input  logic [SLOT_W-1:0] rd_slot_i,
  output logic              rd_valid_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic [7:0]        rd_x_o,
  output logic [3:0]        rd_row_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);

  // FSM and OAM address generation
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic              phase_q;
  logic              oam_rd_q;
  logic [7:0]        oam_addr_q;

  // Read-data pipeline: tags which object/byte the returning OAM data belongs to
  logic              rv_q;
  logic              rph_q;
  logic [IDX_W-1:0]  rptr_q;
  logic              yhit_q;
  logic [3:0]        row_q;

  // Per-scan latched controls
  logic [7:0]        line_q;
  logic              en_q;
  logic              tall_q;

  // Double-buffered list: bank sel_q is front (read), ~sel_q is back (filled)
  logic              sel_q;
  logic [CNT_W-1:0]  cnt_q [2];
  logic [1:0]        ovf_q;
  logic              done_q;
  logic [7:0]        slot_x_q   [2][MAX_PER_LINE];
  logic [IDX_W-1:0]  slot_idx_q [2][MAX_PER_LINE];
  logic [3:0]        slot_row_q [2][MAX_PER_LINE];

  logic              w_start;
  logic              w_finish;
  logic              w_back;
  logic [CNT_W-1:0]  w_back_cnt;
  logic [7:0]        w_row8;
  logic              w_yhit;
  logic              w_xbyte;
  logic              w_ins_en;
  logic              w_drop;
  logic [SLOT_W-1:0] w_ins_pos;
  logic [CNT_W-1:0]  w_front_cnt;
  logic [SLOT_W-1:0] w_rd_sel;
  logic [IDX_W-1:0]  w_ptr_inc;

  assign w_start     = (state_q == ST_IDLE) && start_i;
  // The last X byte is consumed on the FIN edge where rv_q is still set;
  // banks swap one edge later once the pipeline is empty.
  assign w_finish    = (state_q == ST_FIN) && !rv_q;
  assign w_back      = ~sel_q;
  assign w_back_cnt  = cnt_q[w_back];
  assign w_ptr_inc   = ptr_q + IDX_W'(1);

  // Y byte test: wrap-around rows (Y above the line) land at >= 16 and miss.
  assign w_row8      = line_q + 8'd16 - oam_rdata_i;
  assign w_yhit      = en_q && (w_row8 < (tall_q ? 8'd16 : 8'd8));

  assign w_xbyte     = rv_q && rph_q && yhit_q;
  assign w_ins_en    = w_xbyte && (w_back_cnt < MAX_CNT);
  assign w_drop      = w_xbyte && (w_back_cnt >= MAX_CNT);

  // Next-state decode for the scan FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_SCAN;
      ST_SCAN: if (phase_q && (ptr_q == LAST_PTR)) state_d = ST_FIN;
      ST_FIN:  if (!rv_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // OAM address sequencer: 4*ptr+0 (Y), then 4*ptr+1 (X)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q      <= '0;
      phase_q    <= 1'b0;
      oam_rd_q   <= 1'b0;
      oam_addr_q <= '0;
    end else if (w_start) begin
      ptr_q      <= '0;
      phase_q    <= 1'b0;
      oam_rd_q   <= 1'b1;
      oam_addr_q <= '0;
    end else if (state_q == ST_SCAN) begin
      if (!phase_q) begin
        phase_q    <= 1'b1;
        oam_addr_q <= 8'({ptr_q, 2'b01});
      end else if (ptr_q == LAST_PTR) begin
        phase_q    <= 1'b0;
        oam_rd_q   <= 1'b0;
        oam_addr_q <= '0;
      end else begin
        ptr_q      <= w_ptr_inc;
        phase_q    <= 1'b0;
        oam_addr_q <= 8'({w_ptr_inc, 2'b00});
      end
    end
  end

  // Track the one-cycle OAM latency and evaluate the Y byte on arrival
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rv_q   <= 1'b0;
      rph_q  <= 1'b0;
      rptr_q <= '0;
      yhit_q <= 1'b0;
      row_q  <= '0;
    end else begin
      rv_q   <= oam_rd_q;
      rph_q  <= phase_q;
      rptr_q <= ptr_q;
      if (rv_q && !rph_q) begin
        yhit_q <= w_yhit;
        row_q  <= w_row8[3:0];
      end
    end
  end

  // Latch scan controls on the accepted start edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_q <= '0;
      en_q   <= 1'b0;
      tall_q <= 1'b0;
    end else if (w_start) begin
      line_q <= line_i;
      en_q   <= obj_en_i;
      tall_q <= tall_i;
    end
  end

  // Bank select, per-bank count/overflow and the done pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q    <= 1'b0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= w_finish;
      if (w_finish) sel_q <= ~sel_q;
      if (w_start) begin
        cnt_q[w_back] <= '0;
        ovf_q[w_back] <= 1'b0;
      end else if (w_ins_en) begin
        cnt_q[w_back] <= w_back_cnt + CNT_W'(1);
      end else if (w_drop) begin
        ovf_q[w_back] <= 1'b1;
      end
    end
  end

  generate
    if (SORT_BY_X != 0) begin : g_sorted
      // Back list is kept sorted, so the entries with x <= X form a prefix
      // and its length is the insert slot (ties stay in OAM order).
      always_comb begin
        w_ins_pos = '0;
        for (int s = 0; s < MAX_PER_LINE; s++) begin
          if ((CNT_W'(s) < w_back_cnt) && (slot_x_q[w_back][s] <= oam_rdata_i))
            w_ins_pos = w_ins_pos + SLOT_W'(1);
        end
      end
    end else begin : g_append
      assign w_ins_pos = SLOT_W'(w_back_cnt);
    end
  endgenerate

  // Single-cycle insert: shift slots above the insert point up by one
  always_ff @(posedge clk) begin
    if (w_ins_en) begin
      for (int s = 1; s < MAX_PER_LINE; s++) begin
        if (SLOT_W'(s) > w_ins_pos) begin
          slot_x_q[w_back][s]   <= slot_x_q[w_back][s-1];
          slot_idx_q[w_back][s] <= slot_idx_q[w_back][s-1];
          slot_row_q[w_back][s] <= slot_row_q[w_back][s-1];
        end
      end
      slot_x_q[w_back][w_ins_pos]   <= oam_rdata_i;
      slot_idx_q[w_back][w_ins_pos] <= rptr_q;
      slot_row_q[w_back][w_ins_pos] <= row_q;
    end
  end

  assign w_front_cnt = cnt_q[sel_q];
  assign rd_valid_o  = (32'(rd_slot_i) < 32'(w_front_cnt)) &&
                       (32'(rd_slot_i) < MAX_PER_LINE);
  // Keep the array index in range; invalid slots read back as zero.
  assign w_rd_sel    = rd_valid_o ? rd_slot_i : '0;
  assign rd_idx_o    = rd_valid_o ? slot_idx_q[sel_q][w_rd_sel] : '0;
  assign rd_x_o      = rd_valid_o ? slot_x_q[sel_q][w_rd_sel]   : '0;
  assign rd_row_o    = rd_valid_o ? slot_row_q[sel_q][w_rd_sel] : '0;

  assign oam_rd_o    = oam_rd_q;
  assign oam_addr_o  = oam_addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign overflow_o  = ovf_q[sel_q];
  assign count_o     = w_front_cnt;

endmodule

`default_nettype wire
